// File: rtl/eth_sw_np.sv
// eth_sw_np: N-port word switch. Each ingress frames packets into a FWFT FIFO;
// each egress round-robins whole packets selected by the destination in word0.
module eth_sw_np #(
    parameter int          NPORTS       = 4,
    parameter int          DATA_W       = 32,
    parameter int          DEPTH        = 32,
    parameter int unsigned ADDR_BASE    = 'hABCD,
    parameter int          STALL_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic [NPORTS*DATA_W-1:0] inData,
    input  logic [NPORTS-1:0]        inValid,
    input  logic [NPORTS-1:0]        inSop,
    input  logic [NPORTS-1:0]        inEop,
    output logic [NPORTS-1:0]        inStall,
    output logic [NPORTS*DATA_W-1:0] outData,
    output logic [NPORTS-1:0]        outValid,
    output logic [NPORTS-1:0]        outSop,
    output logic [NPORTS-1:0]        outEop,
    output logic [NPORTS*16-1:0]     dropCnt,
    output logic [NPORTS-1:0]        ovfErr
);
    localparam int DST_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0]             req, pop, gnt, head_sop, head_eop;
    logic [NPORTS-1:0][DST_W-1:0]  req_dst;
    logic [NPORTS-1:0][DATA_W-1:0] head_data;
    logic [NPORTS-1:0][NPORTS-1:0] gnt_mat;   // [egress][ingress]

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        eth_sw_np_port #(
            .NPORTS      (NPORTS),
            .DATA_W      (DATA_W),
            .DEPTH       (DEPTH),
            .ADDR_BASE   (ADDR_BASE),
            .STALL_THRESH(STALL_THRESH)
        ) u_port (
            .clk      (clk),
            .resetN   (resetN),
            .in_data  (inData[i*DATA_W +: DATA_W]),
            .in_valid (inValid[i]),
            .in_sop   (inSop[i]),
            .in_eop   (inEop[i]),
            .gnt      (gnt[i]),
            .req      (req[i]),
            .req_dst  (req_dst[i]),
            .pop      (pop[i]),
            .head_data(head_data[i]),
            .head_sop (head_sop[i]),
            .head_eop (head_eop[i]),
            .stall    (inStall[i]),
            .ovf_err  (ovfErr[i]),
            .drop_cnt (dropCnt[i*16 +: 16])
        );
    end

    always_comb begin
        gnt = '0;
        for (int e = 0; e < NPORTS; e++) gnt = gnt | gnt_mat[e];
    end

    for (genvar e = 0; e < NPORTS; e++) begin : g_egr
        logic              locked, win_vld, fwd;
        logic [DST_W-1:0]  owner, last, win, cand;
        logic [NPORTS-1:0] eq_req, gnt_row;
        logic [DATA_W-1:0] o_data;
        logic              o_vld, o_sop, o_eop;

        for (genvar i = 0; i < NPORTS; i++) begin : g_req
            assign eq_req[i] = req[i] && (req_dst[i] == DST_W'(e));
        end

        // Search starts just after the previous winner.
        always_comb begin
            win_vld = 1'b0;
            win     = '0;
            cand    = '0;
            for (int k = 1; k <= NPORTS; k++) begin
                cand = DST_W'((int'(last) + k) % NPORTS);
                if (!win_vld && eq_req[cand]) begin
                    win_vld = 1'b1;
                    win     = cand;
                end
            end
        end

        always_comb begin
            gnt_row = '0;
            if (!locked && win_vld) gnt_row[win] = 1'b1;
        end
        assign gnt_mat[e] = gnt_row;
        assign fwd        = locked && pop[owner];

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                locked <= 1'b0;
                owner  <= '0;
                last   <= DST_W'(NPORTS - 1);
            end else if (!locked) begin
                if (win_vld) begin
                    locked <= 1'b1;
                    owner  <= win;
                    last   <= win;
                end
            end else if (fwd && head_eop[owner]) begin
                locked <= 1'b0;
            end
        end

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                o_vld  <= 1'b0;
                o_sop  <= 1'b0;
                o_eop  <= 1'b0;
                o_data <= '0;
            end else begin
                o_vld <= fwd;
                o_sop <= fwd && head_sop[owner];
                o_eop <= fwd && head_eop[owner];
                if (fwd) o_data <= head_data[owner];
            end
        end

        assign outValid[e]                  = o_vld;
        assign outSop[e]                    = o_sop;
        assign outEop[e]                    = o_eop;
        assign outData[e*DATA_W +: DATA_W]  = o_data;
    end
endmodule

// Per-ingress lane: framer stage, FWFT FIFO and head handler that requests
// an egress, forwards a granted packet, or drains an unroutable one.
module eth_sw_np_port #(
    parameter int          NPORTS       = 4,
    parameter int          DATA_W       = 32,
    parameter int          DEPTH        = 32,
    parameter int unsigned ADDR_BASE    = 'hABCD,
    parameter int          STALL_THRESH = 4,
    localparam int         DST_W        = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              gnt,
    output logic              req,
    output logic [DST_W-1:0]  req_dst,
    output logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_sop,
    output logic              head_eop,
    output logic              stall,
    output logic              ovf_err,
    output logic [15:0]       drop_cnt
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_C = (AW+1)'(STALL_THRESH);

    typedef struct packed {
        logic              eop;
        logic              sop;
        logic [DATA_W-1:0] data;
    } fifo_word_t;

    typedef enum logic {OUT_PKT, IN_PKT} frm_state_t;
    typedef enum logic [1:0] {IDLE, REQ, XFER, DRAIN} hd_state_t;

    frm_state_t frm_state, frm_next;
    hd_state_t  hd_state, hd_next;
    logic       frm_accept, stg_vld, wr_en, empty, full, dst_hit, drop_inc;
    fifo_word_t stg_word, head;
    fifo_word_t mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       cnt, cnt_nxt;
    logic [DATA_W-1:0] dst_off;
    logic [DST_W-1:0]  dst_dec, dst_q;

    always_comb begin
        frm_next   = frm_state;
        frm_accept = 1'b0;
        if (in_valid) begin
            case (frm_state)
                OUT_PKT: if (in_sop) begin
                    frm_accept = 1'b1;
                    if (!in_eop) frm_next = IN_PKT;
                end
                IN_PKT: begin
                    frm_accept = 1'b1;
                    if (in_eop) frm_next = OUT_PKT;
                end
                default: frm_next = OUT_PKT;
            endcase
        end
    end

    // SOP is only honoured when it opens a packet; inside one it is payload.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frm_state <= OUT_PKT;
            stg_vld   <= 1'b0;
            stg_word  <= '0;
        end else begin
            frm_state <= frm_next;
            stg_vld   <= frm_accept;
            stg_word  <= '{eop: in_eop, sop: (frm_state == OUT_PKT), data: in_data};
        end
    end

    assign empty   = (cnt == '0);
    assign full    = (cnt == DEPTH_C);
    assign wr_en   = stg_vld && !full;
    assign head    = mem[rd_ptr];
    assign cnt_nxt = cnt + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= stg_word;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            stall   <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            cnt     <= cnt_nxt;
            stall   <= (DEPTH_C - cnt_nxt) < STALL_C;
            ovf_err <= ovf_err || (stg_vld && full);
        end
    end

    assign head_data = head.data;
    assign head_sop  = head.sop;
    assign head_eop  = head.eop;
    assign dst_off   = head.data - DATA_W'(ADDR_BASE);
    assign dst_hit   = dst_off < DATA_W'(NPORTS);
    assign dst_dec   = dst_off[DST_W-1:0];
    assign req       = (hd_state == REQ) ||
                       (hd_state == IDLE && !empty && head.sop && dst_hit);
    assign req_dst   = (hd_state == REQ) ? dst_q : dst_dec;

    // A grant seen while still in IDLE goes straight to XFER; timing matches
    // IDLE->REQ->XFER since the arbiter registers its lock on the same edge.
    always_comb begin
        hd_next  = hd_state;
        pop      = 1'b0;
        drop_inc = 1'b0;
        case (hd_state)
            IDLE: if (!empty) begin
                if (head.sop) begin
                    if (dst_hit) hd_next = gnt ? XFER : REQ;
                    else         hd_next = DRAIN;
                end else begin
                    pop = 1'b1;   // orphaned tail whose SOP overflowed away
                end
            end
            REQ: if (gnt) hd_next = XFER;
            XFER: if (!empty) begin
                pop = 1'b1;
                if (head.eop) hd_next = IDLE;
            end
            DRAIN: if (!empty) begin
                pop = 1'b1;
                if (head.eop) begin
                    hd_next  = IDLE;
                    drop_inc = 1'b1;
                end
            end
            default: hd_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hd_state <= IDLE;
            dst_q    <= '0;
            drop_cnt <= '0;
        end else begin
            hd_state <= hd_next;
            if (hd_state == IDLE) dst_q <= dst_dec;
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule
